uart_rx_fifo: RTL and testbench



---
 rtl/uart_pkg.sv | 25 ++
 rtl/uart_rx_buffer.sv | 68 ++++++
 rtl/uart_rx_fifo.sv | 138 +++++++++++++
 tb/tb_uart_rx_fifo.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver FSM states, frame-bit constants and
// baud-divisor derivation reused by both the receiver and the transmitter.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    WAIT_IDLE
  } uart_state_t;

  localparam logic START_BIT = 1'b0;
  localparam logic STOP_BIT  = 1'b1;
  localparam int   DATA_BITS = 8;

  function automatic int baud_divisor(input int clock_frequency, input int baud_rate);
    return clock_frequency / baud_rate;
  endfunction

  function automatic int half_divisor(input int clock_frequency, input int baud_rate);
    return baud_divisor(clock_frequency, baud_rate) / 2;
  endfunction

endpackage

// File: rtl/uart_rx_buffer.sv
// First-word-fall-through byte FIFO for the UART receiver; reports a dropped
// write through overflow so the top can keep the sticky overrun flag.
module uart_rx_buffer #(
  parameter int DEPTH = 16,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        wr_en,
  input  logic [7:0]  wr_data,
  input  logic        rd_en,
  output logic [7:0]  rd_data,
  output logic        empty,
  output logic        full,
  output logic [AW:0] count,
  output logic        overflow
);

  localparam logic [AW:0] DEPTH_COUNT = (AW + 1)'(DEPTH);

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr_reg;
  logic [AW-1:0] rd_ptr_reg;
  logic [AW:0]   count_reg;
  logic [AW:0]   count_next;
  logic          do_rd;
  logic          do_wr;

  assign empty    = (count_reg == '0);
  assign full     = (count_reg == DEPTH_COUNT);
  assign count    = count_reg;

  // A pop frees a slot in the same cycle, so a full FIFO can still accept a write.
  assign do_rd    = rd_en & ~empty;
  assign do_wr    = wr_en & (~full | do_rd);
  assign overflow = wr_en & full & ~do_rd;

  // Head is read combinationally so the byte is presented without a pop.
  assign rd_data  = empty ? 8'h00 : mem[rd_ptr_reg];

  always_comb begin
    count_next = count_reg;
    if (do_wr && !do_rd) begin
      count_next = count_reg + 1'b1;
    end else if (do_rd && !do_wr) begin
      count_next = count_reg - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_wr) begin
      mem[wr_ptr_reg] <= wr_data;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (do_wr) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (do_rd) rd_ptr_reg <= rd_ptr_reg + 1'b1;
      count_reg <= count_next;
    end
  end

endmodule

// File: rtl/uart_rx_fifo.sv
// UART 8N1 receiver: synchroniser, 3-sample majority filter, frame FSM and
// sticky error flags, feeding a FWFT receive buffer.
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int CLOCK_FREQUENCY = 27000000,
  parameter int BAUD_RATE       = 115200,
  parameter int FIFO_DEPTH      = 16
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic                          uart_rx_pin,
  input  logic                          rd_en,
  input  logic                          clear_errors,
  output logic [7:0]                    rd_data,
  output logic                          rx_fifo_empty,
  output logic                          rx_fifo_full,
  output logic [$clog2(FIFO_DEPTH):0]   rx_fifo_count,
  output logic                          frame_error,
  output logic                          overrun_error
);

  localparam logic [15:0] DIV_LAST  = 16'(baud_divisor(CLOCK_FREQUENCY, BAUD_RATE) - 1);
  localparam logic [15:0] HALF_LAST = 16'(half_divisor(CLOCK_FREQUENCY, BAUD_RATE) - 1);

  logic        sync1_reg;
  logic        sync2_reg;
  logic [2:0]  window_reg;
  logic        sample;
  uart_state_t state_reg, state_next;
  logic [15:0] count_reg, count_next;
  logic [2:0]  bit_reg, bit_next;
  logic [7:0]  shift_reg, shift_next;
  logic        frame_error_reg;
  logic        overrun_error_reg;
  logic        wr_en;
  logic        frame_error_set;
  logic        overflow;

  assign sample = (window_reg[0] & window_reg[1]) |
                  (window_reg[0] & window_reg[2]) |
                  (window_reg[1] & window_reg[2]);

  always_comb begin
    state_next      = state_reg;
    count_next      = count_reg + 16'd1;
    bit_next        = bit_reg;
    shift_next      = shift_reg;
    wr_en           = 1'b0;
    frame_error_set = 1'b0;
    case (state_reg)
      IDLE: begin
        count_next = '0;
        if (sync2_reg == START_BIT) state_next = START;
      end
      START: begin
        // Re-check the start bit at mid-bit to reject short low glitches.
        if (count_reg == HALF_LAST) begin
          count_next = '0;
          bit_next   = '0;
          state_next = (sample == START_BIT) ? DATA : IDLE;
        end
      end
      DATA: begin
        if (count_reg == DIV_LAST) begin
          count_next = '0;
          shift_next = {sample, shift_reg[7:1]};
          bit_next   = bit_reg + 3'd1;
          if (bit_reg == 3'(DATA_BITS - 1)) state_next = STOP;
        end
      end
      STOP: begin
        if (count_reg == DIV_LAST) begin
          count_next = '0;
          if (sample == STOP_BIT) begin
            wr_en      = 1'b1;
            state_next = IDLE;
          end else begin
            frame_error_set = 1'b1;
            state_next      = WAIT_IDLE;
          end
        end
      end
      WAIT_IDLE: begin
        // A held-low break must not retrigger frames until the line idles.
        count_next = '0;
        if (sync2_reg == STOP_BIT) state_next = IDLE;
      end
      default: begin
        count_next = '0;
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1_reg         <= 1'b1;
      sync2_reg         <= 1'b1;
      window_reg        <= 3'b111;
      state_reg         <= IDLE;
      count_reg         <= '0;
      bit_reg           <= '0;
      shift_reg         <= '0;
      frame_error_reg   <= 1'b0;
      overrun_error_reg <= 1'b0;
    end else begin
      sync1_reg         <= uart_rx_pin;
      sync2_reg         <= sync1_reg;
      window_reg        <= {window_reg[1:0], sync2_reg};
      state_reg         <= state_next;
      count_reg         <= count_next;
      bit_reg           <= bit_next;
      shift_reg         <= shift_next;
      frame_error_reg   <= frame_error_set | (frame_error_reg & ~clear_errors);
      overrun_error_reg <= overflow | (overrun_error_reg & ~clear_errors);
    end
  end

  assign frame_error   = frame_error_reg;
  assign overrun_error = overrun_error_reg;

  uart_rx_buffer #(
    .DEPTH(FIFO_DEPTH)
  ) u_buffer (
    .clk     (clk),
    .reset_n (reset_n),
    .wr_en   (wr_en),
    .wr_data (shift_reg),
    .rd_en   (rd_en),
    .rd_data (rd_data),
    .empty   (rx_fifo_empty),
    .full    (rx_fifo_full),
    .count   (rx_fifo_count),
    .overflow(overflow)
  );

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Self-checking bench for uart_rx_fifo at 10 clocks per bit with a 16-entry
// buffer; received bytes are scoreboarded through a queue.
module tb_uart_rx_fifo;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       uart_rx_pin;
  logic       rd_en;
  logic       clear_errors;
  logic [7:0] rd_data;
  logic       rx_fifo_empty;
  logic       rx_fifo_full;
  logic [4:0] rx_fifo_count;
  logic       frame_error;
  logic       overrun_error;

  int total = 0;
  int bad   = 0;
  logic [7:0] exp_q[$];

  typedef struct {
    logic [7:0] data;
    logic       stop;
    int         hold_low;
    int         exp_count;
    logic       exp_fe;
    bit         lat;
  } vec_t;

  vec_t vecs[4];

  uart_rx_fifo #(
    .CLOCK_FREQUENCY(1000000),
    .BAUD_RATE      (100000),
    .FIFO_DEPTH     (16)
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .uart_rx_pin  (uart_rx_pin),
    .rd_en        (rd_en),
    .clear_errors (clear_errors),
    .rd_data      (rd_data),
    .rx_fifo_empty(rx_fifo_empty),
    .rx_fifo_full (rx_fifo_full),
    .rx_fifo_count(rx_fifo_count),
    .frame_error  (frame_error),
    .overrun_error(overrun_error)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: got=timeout want=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h", name, act, exp);
    end
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_empty"}, 32'(rx_fifo_empty), 32'd1);
    check({tag, "_full"},  32'(rx_fifo_full),  32'd0);
    check({tag, "_count"}, 32'(rx_fifo_count), 32'd0);
    check({tag, "_data"},  32'(rd_data),       32'd0);
    check({tag, "_fe"},    32'(frame_error),   32'd0);
    check({tag, "_oe"},    32'(overrun_error), 32'd0);
  endtask

  // One 100-cycle frame driven on negedges. Bit b occupies cycles 10b..10b+9;
  // the DUT's stop sample commits on the posedge just after cycle 97.
  task automatic send_frame(input logic [7:0] d, input logic stop, input int pop_at,
                            input int rst_at, input bit lat);
    for (int c = 0; c < 100; c++) begin
      automatic int b = c / 10;
      if (rst_at >= 0 && c >= rst_at) uart_rx_pin = 1'b1;
      else if (b == 0)                uart_rx_pin = 1'b0;
      else if (b == 9)                uart_rx_pin = stop;
      else                            uart_rx_pin = d[b-1];
      if (rst_at >= 0 && c == rst_at) reset_n = 1'b0;
      if (rst_at >= 0 && c == rst_at + 3) begin
        check_reset_values("midreset");
        reset_n = 1'b1;
      end
      rd_en = 1'b0;
      if (c == pop_at) begin
        if (exp_q.size() > 0) begin
          check("pop_head", 32'(rd_data), 32'(exp_q[0]));
          void'(exp_q.pop_front());
        end
        rd_en = 1'b1;
      end
      if (lat && c == 97) check("lat_before", 32'(rx_fifo_empty), 32'd1);
      if (lat && c == 98) begin
        check("lat_empty", 32'(rx_fifo_empty), 32'd0);
        check("lat_data",  32'(rd_data),       32'(d));
        check("lat_count", 32'(rx_fifo_count), 32'd1);
      end
      @(negedge clk);
    end
    rd_en = 1'b0;
    $display("frame %02h stop=%0d sent", d, stop);
  endtask

  task automatic drain();
    while (exp_q.size() > 0) begin
      automatic logic [7:0] e = exp_q.pop_front();
      check("head_valid", 32'(rx_fifo_empty), 32'd0);
      check("rd_data",    32'(rd_data),       32'(e));
      $display("read %02h expected %02h", rd_data, e);
      rd_en = 1'b1;
      @(negedge clk);
      rd_en = 1'b0;
    end
    check("drained_empty", 32'(rx_fifo_empty), 32'd1);
    check("drained_count", 32'(rx_fifo_count), 32'd0);
  endtask

  task automatic pulse_clear();
    clear_errors = 1'b1;
    @(negedge clk);
    clear_errors = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    vecs[0] = '{data: 8'hA5, stop: 1'b1, hold_low: 0,  exp_count: 1, exp_fe: 1'b0, lat: 1'b1};
    vecs[1] = '{data: 8'h3C, stop: 1'b0, hold_low: 50, exp_count: 0, exp_fe: 1'b1, lat: 1'b0};
    vecs[2] = '{data: 8'h55, stop: 1'b1, hold_low: 0,  exp_count: 1, exp_fe: 1'b1, lat: 1'b0};
    vecs[3] = '{data: 8'hC3, stop: 1'b1, hold_low: 0,  exp_count: 1, exp_fe: 1'b1, lat: 1'b0};

    reset_n      = 1'b0;
    uart_rx_pin  = 1'b1;
    rd_en        = 1'b0;
    clear_errors = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_values("reset");
    reset_n = 1'b1;
    @(negedge clk);

    // Short low glitch must be rejected silently.
    uart_rx_pin = 1'b0;
    repeat (3) @(negedge clk);
    uart_rx_pin = 1'b1;
    repeat (30) @(negedge clk);
    check("glitch_empty", 32'(rx_fifo_empty), 32'd1);
    check("glitch_fe",    32'(frame_error),   32'd0);
    check("glitch_oe",    32'(overrun_error), 32'd0);
    $display("glitch applied");

    foreach (vecs[i]) begin
      send_frame(vecs[i].data, vecs[i].stop, -1, -1, vecs[i].lat);
      repeat (vecs[i].hold_low) @(negedge clk);
      uart_rx_pin = 1'b1;
      repeat (20) @(negedge clk);
      check("vec_count", 32'(rx_fifo_count), 32'(vecs[i].exp_count));
      check("vec_fe",    32'(frame_error),   32'(vecs[i].exp_fe));
      check("vec_oe",    32'(overrun_error), 32'd0);
      if (vecs[i].stop) exp_q.push_back(vecs[i].data);
      drain();
    end

    pulse_clear();
    check("clear_fe", 32'(frame_error), 32'd0);

    // Fill past capacity: 16 accepted, the 17th dropped.
    for (int i = 0; i < 17; i++) begin
      send_frame(8'(i), 1'b1, -1, -1, 1'b0);
      repeat (2) @(negedge clk);
      if (i < 16) exp_q.push_back(8'(i));
      if (i == 15) begin
        check("fill_full",  32'(rx_fifo_full),  32'd1);
        check("fill_count", 32'(rx_fifo_count), 32'd16);
        check("fill_oe",    32'(overrun_error), 32'd0);
      end
      if (i == 16) begin
        check("ovr_oe",    32'(overrun_error), 32'd1);
        check("ovr_count", 32'(rx_fifo_count), 32'd16);
      end
    end
    drain();
    check("ovr_sticky", 32'(overrun_error), 32'd1);
    pulse_clear();
    check("ovr_clear", 32'(overrun_error), 32'd0);

    // Full FIFO: pop coincides with the next write.
    for (int i = 0; i < 16; i++) begin
      send_frame(8'h20 + 8'(i), 1'b1, -1, -1, 1'b0);
      repeat (2) @(negedge clk);
      exp_q.push_back(8'h20 + 8'(i));
    end
    check("rw_full_pre", 32'(rx_fifo_full), 32'd1);
    send_frame(8'h30, 1'b1, 97, -1, 1'b0);
    exp_q.push_back(8'h30);
    repeat (2) @(negedge clk);
    check("rw_count", 32'(rx_fifo_count), 32'd16);
    check("rw_oe",    32'(overrun_error), 32'd0);
    drain();

    // Pops while empty are ignored, also when coinciding with a write.
    rd_en = 1'b1;
    repeat (2) @(negedge clk);
    rd_en = 1'b0;
    check("emptyrd_count", 32'(rx_fifo_count), 32'd0);
    send_frame(8'h42, 1'b1, 97, -1, 1'b0);
    repeat (2) @(negedge clk);
    check("emptyrw_count", 32'(rx_fifo_count), 32'd1);
    exp_q.push_back(8'h42);
    drain();

    // Reset mid-frame discards buffered data and the partial frame.
    send_frame(8'h99, 1'b1, -1, -1, 1'b0);
    repeat (2) @(negedge clk);
    check("prereset_count", 32'(rx_fifo_count), 32'd1);
    send_frame(8'h77, 1'b1, -1, 55, 1'b0);
    repeat (20) @(negedge clk);
    check_reset_values("postreset");
    send_frame(8'h81, 1'b1, -1, -1, 1'b0);
    repeat (2) @(negedge clk);
    check("final_count", 32'(rx_fifo_count), 32'd1);
    exp_q.push_back(8'h81);
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
